// File: rtl/hdu_pipe_tracker_pkg.sv
// rtl/hdu_pipe_tracker_pkg.sv - pipeline stage record layout and instruction field positions
package hdu_pipe_tracker_pkg;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [REG_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      rfen;
        logic      mrd;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    function automatic reg_addr_t reg_field(input logic [31:0] instr, input int lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/hdu_pipe_tracker_if.sv
// rtl/hdu_pipe_tracker_if.sv - fetch/CU/HDU signal bundle seen by the pipe tracker
interface hdu_pipe_tracker_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      INSTR_IF_IN;
    logic             INSTR_VALID_IN;
    logic             STALL_IN;
    logic             FLUSH_IN;
    logic             WB_RFEN_IN;
    logic             M_RD_IN;

    logic [31:0]      ID_INSTR_OUT;
    logic             IF_HOLD_OUT;
    logic [4:0]       RS1_ID_OUT;
    logic [4:0]       RS2_ID_OUT;
    logic [4:0]       RS1_EXE_OUT;
    logic [4:0]       RS2_EXE_OUT;
    logic [4:0]       RD_EX_OUT;
    logic [4:0]       RD_MEM_OUT;
    logic [4:0]       RD_WB_OUT;
    logic             LOAD_EXE_OUT;
    logic             REG_WR_MEM_OUT;
    logic             REG_WR_WB_OUT;
    logic [CNT_W-1:0] STALL_CNT_OUT;
    logic [CNT_W-1:0] FLUSH_CNT_OUT;

    modport master (
        output INSTR_IF_IN, INSTR_VALID_IN, STALL_IN, FLUSH_IN, WB_RFEN_IN, M_RD_IN,
        input  ID_INSTR_OUT, IF_HOLD_OUT, RS1_ID_OUT, RS2_ID_OUT, RS1_EXE_OUT, RS2_EXE_OUT,
               RD_EX_OUT, RD_MEM_OUT, RD_WB_OUT, LOAD_EXE_OUT, REG_WR_MEM_OUT, REG_WR_WB_OUT,
               STALL_CNT_OUT, FLUSH_CNT_OUT
    );

    modport slave (
        input  INSTR_IF_IN, INSTR_VALID_IN, STALL_IN, FLUSH_IN, WB_RFEN_IN, M_RD_IN,
        output ID_INSTR_OUT, IF_HOLD_OUT, RS1_ID_OUT, RS2_ID_OUT, RS1_EXE_OUT, RS2_EXE_OUT,
               RD_EX_OUT, RD_MEM_OUT, RD_WB_OUT, LOAD_EXE_OUT, REG_WR_MEM_OUT, REG_WR_WB_OUT,
               STALL_CNT_OUT, FLUSH_CNT_OUT
    );

endinterface

// File: rtl/hdu_pipe_tracker_sat_counter.sv
// rtl/hdu_pipe_tracker_sat_counter.sv - saturating event counter with synchronous clear
module hdu_pipe_tracker_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hdu_pipe_tracker.sv
// rtl/hdu_pipe_tracker.sv - carries hazard-relevant fields through ID/EX/MEM/WB and applies stall/flush
module hdu_pipe_tracker #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     CLK,
    input  logic                     RST,
    hdu_pipe_tracker_if.slave        bus
);
    import hdu_pipe_tracker_pkg::*;

    logic        id_valid;
    logic [31:0] id_instr;
    stage_t      id_dec;
    stage_t      ex_q;
    stage_t      mem_q;
    stage_t      wb_q;

    // CU decode of a bubble is masked so EX never picks up stray rfen/mrd.
    always_comb begin
        id_dec       = STAGE_BUBBLE;
        id_dec.valid = id_valid;
        if (id_valid) begin
            id_dec.rs1  = reg_field(id_instr, RS1_LSB);
            id_dec.rs2  = reg_field(id_instr, RS2_LSB);
            id_dec.rd   = reg_field(id_instr, RD_LSB);
            id_dec.rfen = bus.WB_RFEN_IN;
            id_dec.mrd  = bus.M_RD_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            ex_q     <= STAGE_BUBBLE;
            mem_q    <= STAGE_BUBBLE;
            wb_q     <= STAGE_BUBBLE;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bus.FLUSH_IN) begin
                id_valid <= 1'b0;
                id_instr <= '0;
                ex_q     <= STAGE_BUBBLE;
            end else if (bus.STALL_IN) begin
                ex_q <= STAGE_BUBBLE;
            end else begin
                id_valid <= bus.INSTR_VALID_IN;
                id_instr <= bus.INSTR_IF_IN;
                ex_q     <= id_dec;
            end
        end
    end

    function automatic reg_addr_t gate(input logic valid, input reg_addr_t addr);
        return valid ? addr : '0;
    endfunction

    assign bus.ID_INSTR_OUT   = id_valid ? id_instr : NOP_INSTR;
    assign bus.IF_HOLD_OUT    = bus.STALL_IN & ~bus.FLUSH_IN;
    assign bus.RS1_ID_OUT     = id_dec.rs1;
    assign bus.RS2_ID_OUT     = id_dec.rs2;
    assign bus.RS1_EXE_OUT    = gate(ex_q.valid, ex_q.rs1);
    assign bus.RS2_EXE_OUT    = gate(ex_q.valid, ex_q.rs2);
    assign bus.RD_EX_OUT      = gate(ex_q.valid, ex_q.rd);
    assign bus.RD_MEM_OUT     = gate(mem_q.valid, mem_q.rd);
    assign bus.RD_WB_OUT      = gate(wb_q.valid, wb_q.rd);
    assign bus.LOAD_EXE_OUT   = ex_q.valid & ex_q.mrd;
    assign bus.REG_WR_MEM_OUT = mem_q.valid & mem_q.rfen;
    assign bus.REG_WR_WB_OUT  = wb_q.valid & wb_q.rfen;

    // A flush that coincides with a stall counts only as a flush.
    hdu_pipe_tracker_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clr   (RST),
        .en    (bus.STALL_IN & ~bus.FLUSH_IN),
        .count (bus.STALL_CNT_OUT)
    );

    hdu_pipe_tracker_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clr   (RST),
        .en    (bus.FLUSH_IN),
        .count (bus.FLUSH_CNT_OUT)
    );

endmodule

// File: tb/tb_hdu_pipe_tracker.sv
// tb/tb_hdu_pipe_tracker.sv - directed self-checking bench for hdu_pipe_tracker
module tb_hdu_pipe_tracker;

    localparam int CNT_W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;

    hdu_pipe_tracker_if #(.CNT_W(CNT_W)) bus ();

    hdu_pipe_tracker #(.CNT_W(CNT_W), .NOP_INSTR(32'h0000_0013)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.INSTR_IF_IN    = 32'h0;
        bus.INSTR_VALID_IN = 1'b0;
        bus.STALL_IN       = 1'b0;
        bus.FLUSH_IN       = 1'b0;
        bus.WB_RFEN_IN     = 1'b0;
        bus.M_RD_IN        = 1'b0;

        step();
        step();
        check("rst_id_instr", bus.ID_INSTR_OUT, 32'h0000_0013);
        check("rst_rs1_id", bus.RS1_ID_OUT, 0);
        check("rst_rd_ex", bus.RD_EX_OUT, 0);
        check("rst_rd_wb", bus.RD_WB_OUT, 0);
        check("rst_load", bus.LOAD_EXE_OUT, 0);
        check("rst_regwr_wb", bus.REG_WR_WB_OUT, 0);
        check("rst_stall_cnt", bus.STALL_CNT_OUT, 0);
        check("rst_flush_cnt", bus.FLUSH_CNT_OUT, 0);
        RST = 1'b0;

        // addi x1,x0,1 ; add x2,x1,x1
        bus.INSTR_IF_IN = 32'h0010_0093; bus.INSTR_VALID_IN = 1'b1; bus.WB_RFEN_IN = 1'b1;
        step();
        bus.INSTR_IF_IN = 32'h0010_8133;
        step();
        check("sl_rd_ex", bus.RD_EX_OUT, 1);
        check("sl_rs1_id", bus.RS1_ID_OUT, 1);
        check("sl_rs2_id", bus.RS2_ID_OUT, 1);
        bus.INSTR_VALID_IN = 1'b0;
        step();
        step();
        check("sl_rd_wb", bus.RD_WB_OUT, 1);
        check("sl_regwr_wb", bus.REG_WR_WB_OUT, 1);
        check("sl_rd_mem", bus.RD_MEM_OUT, 2);
        step();
        step();
        check("sl_drain_regwr_wb", bus.REG_WR_WB_OUT, 0);

        // lw x5,0(x0) ; add x6,x5,x7 with one stall cycle
        bus.INSTR_IF_IN = 32'h0000_2283; bus.INSTR_VALID_IN = 1'b1; bus.M_RD_IN = 1'b0;
        step();
        bus.M_RD_IN = 1'b1; bus.INSTR_IF_IN = 32'h0072_8333;
        step();
        check("lu_load_exe", bus.LOAD_EXE_OUT, 1);
        check("lu_rs1_id", bus.RS1_ID_OUT, 5);
        check("lu_rs2_id", bus.RS2_ID_OUT, 7);
        check("lu_rd_ex", bus.RD_EX_OUT, 5);
        bus.STALL_IN = 1'b1; bus.M_RD_IN = 1'b0; bus.INSTR_IF_IN = 32'h0000_0013;
        #1;
        check("lu_if_hold", bus.IF_HOLD_OUT, 1);
        step();
        check("lu_id_held", bus.ID_INSTR_OUT, 32'h0072_8333);
        check("lu_ex_bubble", bus.RD_EX_OUT, 0);
        check("lu_load_bubble", bus.LOAD_EXE_OUT, 0);
        check("lu_rd_mem", bus.RD_MEM_OUT, 5);
        check("lu_stall_cnt", bus.STALL_CNT_OUT, 1);
        bus.STALL_IN = 1'b0;
        #1;
        check("lu_if_release", bus.IF_HOLD_OUT, 0);
        step();
        check("lu_rd_ex_after", bus.RD_EX_OUT, 6);
        check("lu_rs1_exe", bus.RS1_EXE_OUT, 5);
        check("lu_rs2_exe", bus.RS2_EXE_OUT, 7);
        check("lu_rd_wb", bus.RD_WB_OUT, 5);
        check("lu_regwr_wb", bus.REG_WR_WB_OUT, 1);
        check("lu_id_next", bus.ID_INSTR_OUT, 32'h0000_0013);

        // addi x3,x0,3 reaches MEM, then flush together with stall
        bus.INSTR_IF_IN = 32'h0030_0193;
        step();
        bus.INSTR_IF_IN = 32'h0010_8133;
        step();
        step();
        check("fl_rd_mem_pre", bus.RD_MEM_OUT, 3);
        bus.STALL_IN = 1'b1; bus.FLUSH_IN = 1'b1;
        #1;
        check("fl_if_hold", bus.IF_HOLD_OUT, 0);
        step();
        check("fl_id_bubble", bus.ID_INSTR_OUT, 32'h0000_0013);
        check("fl_rs1_id", bus.RS1_ID_OUT, 0);
        check("fl_rd_ex", bus.RD_EX_OUT, 0);
        check("fl_rd_mem", bus.RD_MEM_OUT, 2);
        check("fl_rd_wb", bus.RD_WB_OUT, 3);
        check("fl_flush_cnt", bus.FLUSH_CNT_OUT, 1);
        check("fl_stall_cnt", bus.STALL_CNT_OUT, 1);

        // 20 stalled cycles saturate a 4-bit counter
        bus.FLUSH_IN = 1'b0;
        repeat (20) step();
        check("sat_stall_cnt", bus.STALL_CNT_OUT, 15);
        step();
        check("sat_stall_hold", bus.STALL_CNT_OUT, 15);
        check("sat_flush_cnt", bus.FLUSH_CNT_OUT, 1);

        // fill pipe, then reset while stalled
        bus.STALL_IN = 1'b0; bus.INSTR_IF_IN = 32'h0072_8333; bus.M_RD_IN = 1'b1;
        repeat (4) step();
        check("mr_full_rd_wb", bus.RD_WB_OUT, 6);
        check("mr_full_load", bus.LOAD_EXE_OUT, 1);
        check("mr_full_regwr_mem", bus.REG_WR_MEM_OUT, 1);
        bus.STALL_IN = 1'b1; RST = 1'b1;
        step();
        check("mr_id_instr", bus.ID_INSTR_OUT, 32'h0000_0013);
        check("mr_rs1_id", bus.RS1_ID_OUT, 0);
        check("mr_rd_ex", bus.RD_EX_OUT, 0);
        check("mr_rd_mem", bus.RD_MEM_OUT, 0);
        check("mr_rd_wb", bus.RD_WB_OUT, 0);
        check("mr_load", bus.LOAD_EXE_OUT, 0);
        check("mr_regwr_wb", bus.REG_WR_WB_OUT, 0);
        check("mr_stall_cnt", bus.STALL_CNT_OUT, 0);
        check("mr_flush_cnt", bus.FLUSH_CNT_OUT, 0);
        RST = 1'b0; bus.STALL_IN = 1'b0; bus.M_RD_IN = 1'b0; bus.INSTR_IF_IN = 32'h0010_0093;
        step();
        check("mr_first_id", bus.ID_INSTR_OUT, 32'h0010_0093);
        check("mr_first_rs2", bus.RS2_ID_OUT, 1);
        check("mr_first_rd_ex", bus.RD_EX_OUT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hdu_pipe_tracker.md
Name: hdu_pipe_tracker

Overview:
- Producer side of the hazard-detection / forwarding-unit interface.
- Carries the register-address fields and hazard-relevant control bits of each in-flight instruction through the ID/EX/MEM/WB pipeline registers.
- Presents RS/RD/load/reg-write information per stage to the HDU.
- Applies the HDU's STALL (bubble insertion, ID hold) and the CU's PIPE_FLUSH back onto the pipeline; counts stall and flush events for performance checks.

Parameters:
- CNT_W, 16, width of the saturating stall/flush event counters
- NOP_INSTR, 32'h00000013, instruction word presented in ID when ID holds a bubble (addi x0,x0,0)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset
- INSTR_IF_IN  in  32  instruction word from fetch
- INSTR_VALID_IN  in  1  INSTR_IF_IN is a real instruction
- STALL_IN  in  1  load-use stall from HDU
- FLUSH_IN  in  1  pipe flush from CU (branch mispredict)
- WB_RFEN_IN  in  1  CU decode of ID instruction: writes register file
- M_RD_IN  in  1  CU decode of ID instruction: memory read (load)
- ID_INSTR_OUT  out  32  instruction currently in ID (drives CU opcode decode)
- IF_HOLD_OUT  out  1  PC/IF register write disable
- RS1_ID_OUT, RS2_ID_OUT  out  5 each  ID source registers
- RS1_EXE_OUT, RS2_EXE_OUT  out  5 each  EX source registers
- RD_EX_OUT, RD_MEM_OUT, RD_WB_OUT  out  5 each  destination register per stage
- LOAD_EXE_OUT  out  1  EX instruction is a valid load
- REG_WR_MEM_OUT, REG_WR_WB_OUT  out  1 each  MEM/WB instruction is valid and writes the RF
- STALL_CNT_OUT, FLUSH_CNT_OUT  out  CNT_W each  saturating event counters

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - all stage valid bits 0, all stored fields 0, counters 0
  - ID_INSTR_OUT=NOP_INSTR
  - every other output 0 the cycle after; RST overrides STALL_IN/FLUSH_IN.
- Stage state:
  - ID holds {valid, instr[31:0]}.
  - EX/MEM/WB each hold {valid, rs1, rs2, rd, rfen, mrd}.
  - Fields decoded as rs1=[19:15], rs2=[24:20], rd=[11:7].
- Output gating:
  - Outputs are registered-state driven, with zero additional latency.
  - Every field output reads 0 when its stage is invalid.
  - ID_INSTR_OUT=NOP_INSTR when ID is invalid.
  - LOAD_EXE_OUT = EX.valid & EX.mrd.
  - REG_WR_x_OUT = x.valid & x.rfen.
  - IF_HOLD_OUT = STALL_IN & ~FLUSH_IN (combinational).
- Update priority at each rising edge (RST > FLUSH > STALL > normal):
  - Normal:
    - ID <= {INSTR_VALID_IN, INSTR_IF_IN}
    - EX <= ID fields with rfen=WB_RFEN_IN & ID.valid, mrd=M_RD_IN & ID.valid
    - MEM <= EX; WB <= MEM
  - STALL_IN=1, FLUSH_IN=0:
    - ID holds its contents
    - EX <= bubble (valid=0, all fields 0)
    - MEM <= EX; WB <= MEM
    - STALL_CNT increments
  - FLUSH_IN=1 (regardless of STALL_IN):
    - ID <= bubble; EX <= bubble
    - MEM <= EX; WB <= MEM
    - FLUSH_CNT increments; STALL_CNT is not incremented
- Valid bubbles:
  - INSTR_VALID_IN=0 in the normal case loads an ID bubble.
  - CU outputs for a bubble are masked by ID.valid.
- rd=x0: carried unchanged through the stages; the HDU ignores it. No special-casing here.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- Back-to-back stalls: ID holds for as many cycles as STALL_IN remains high; one EX bubble is inserted per stalled cycle.

Decomposition:
- Shared package (pipeline fields):
  - stage record layout {valid, rs1, rs2, rd, rfen, mrd}
  - field bit positions (RS1_LSB=15, RS2_LSB=20, RD_LSB=7, REG_W=5)
  - NOP_INSTR constant
- One sub-module: sat_counter (CNT_W, enable, synchronous clear), instantiated twice for stall and flush counts.
- Stage registers stay inline.

Test Plan:
- Reset, then release:
  - all RS/RD outputs 0, LOAD_EXE_OUT=0, REG_WR_*=0, counters 0
  - ID_INSTR_OUT=32'h00000013
- Straight line: addi x1,x0,1 then add x2,x1,x1 with WB_RFEN_IN=1 for both:
  - after 2 edges RD_EX_OUT=1, RS1_ID_OUT=1, RS2_ID_OUT=1
  - after 4 edges RD_WB_OUT=1, REG_WR_WB_OUT=1
- Load-use: lw x5,0(x0) (M_RD_IN=1) followed by add x6,x5,x7; drive STALL_IN=1 for one cycle when LOAD_EXE_OUT=1 and RS1_ID_OUT=5:
  - ID_INSTR_OUT unchanged next cycle; EX invalid (RD_EX_OUT=0)
  - RD_MEM_OUT=5; STALL_CNT_OUT=1; IF_HOLD_OUT=1 during the stall
- Flush with STALL_IN=1 simultaneously and MEM holding rd=3:
  - ID and EX become bubbles; RD_WB_OUT=3 next edge
  - FLUSH_CNT_OUT=1, STALL_CNT_OUT unchanged, IF_HOLD_OUT=0
- Saturation: CNT_W=4, STALL_IN=1 for 20 cycles → STALL_CNT_OUT=15 and remains 15.
- Mid-operation reset: RST asserted while STALL_IN=1 and the pipe is full → all outputs 0 and counters 0 after that edge; the first instruction after release appears in ID one edge later.
